// File: rtl/pairing_result_uart_tx.sv
// Result-dump stage: reads words from the pairing core, sends them MSB-byte first as 8N1 UART frames.
// Optional trailing XOR checksum frame when PAIRING_UART_TX_CHECKSUM_EN is defined.
module pairing_result_uart_tx #(
  parameter int DATA_W       = 304,
  parameter int ADDR_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] n_words,
  output logic [ADDR_W-1:0] extout_addr,
  input  logic [DATA_W-1:0] extout_data,
  output logic              busy,
  output logic              done,
  output logic              uart_tx
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int FR_W   = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RD_LAT - 1);

`ifdef PAIRING_UART_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] words_left;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [7:0]        tx_byte;
  logic [FR_W-1:0]   frames_left;
  logic [3:0]        bit_cnt;
  logic [CNT_W-1:0]  clk_cnt;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      words_left  <= '0;
      wait_cnt    <= '0;
      shift_reg   <= '0;
      tx_byte     <= '0;
      frames_left <= '0;
      bit_cnt     <= '0;
      clk_cnt     <= '0;
      extout_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      uart_tx     <= 1'b1;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            words_left  <= n_words;
            extout_addr <= base_addr;
            busy        <= 1'b1;
            wait_cnt    <= '0;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
            csum        <= '0;
`endif
            state       <= (n_words == '0) ? FIN : FETCH;
          end
        end
        FETCH: begin
          if (wait_cnt == WAIT_END) begin
            // Pretend a stop bit is just ending so the first start bit goes out on the next edge.
            shift_reg   <= extout_data;
            frames_left <= FR_W'(NBYTES);
            bit_cnt     <= 4'd9;
            clk_cnt     <= BIT_END;
            state       <= SEND;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
`ifdef PAIRING_UART_TX_CHECKSUM_EN
        SEND, CSUM: begin
`else
        SEND: begin
`endif
          if (clk_cnt != BIT_END) begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end else begin
            clk_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              bit_cnt <= bit_cnt + 4'd1;
              uart_tx <= (bit_cnt == 4'd8) ? 1'b1 : tx_byte[bit_cnt[2:0]];
            end else if (frames_left != '0) begin
              tx_byte     <= shift_reg[DATA_W-1 -: 8];
              shift_reg   <= shift_reg << 8;
              frames_left <= frames_left - FR_W'(1);
              bit_cnt     <= '0;
              uart_tx     <= 1'b0;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
              csum        <= csum ^ shift_reg[DATA_W-1 -: 8];
`endif
            end else if (state == SEND && words_left != ADDR_W'(1)) begin
              words_left  <= words_left - ADDR_W'(1);
              extout_addr <= extout_addr + ADDR_W'(1);
              wait_cnt    <= '0;
              state       <= FETCH;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
            end else if (state == SEND) begin
              tx_byte <= csum;
              bit_cnt <= '0;
              uart_tx <= 1'b0;
              state   <= CSUM;
`endif
            end else begin
              // Finish directly so done lands on the edge the last stop bit ends.
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_result_uart_tx.sv
// Bench for pairing_result_uart_tx: waveform model checked every cycle plus literal pins.
module tb_pairing_result_uart_tx;
  localparam int DATA_W = 304;
  localparam int ADDR_W = 8;
  localparam int CPB    = 4;
  localparam int RDL    = 2;
  localparam int NB     = DATA_W / 8;
`ifdef PAIRING_UART_TX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int NB_EXP   = NB + (CS ? 1 : 0);
  localparam int DONE_EXP = NB * 10 * CPB + (CS ? 10 * CPB : 0);

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] n_words = '0;
  logic [ADDR_W-1:0] extout_addr;
  logic [DATA_W-1:0] extout_data;
  logic              busy, done, uart_tx;

  pairing_result_uart_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB), .RD_LAT(RDL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .n_words(n_words),
    .extout_addr(extout_addr), .extout_data(extout_data), .busy(busy), .done(done), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Core memory model with RD_LAT = 2: one register stage after the address register.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] ext_q;
  always @(posedge clk) ext_q <= mem[extout_addr];
  assign extout_data = ext_q;

  typedef struct packed { logic tx; logic busy; logic done; logic [7:0] addr; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] idle_addr = 8'h00;
  int         compared = 0, mismatched = 0;
  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] addr_log[$];
  int         e0, done_at;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle-by-cycle comparison against the expected waveform.
  exp_t e, act;
  initial forever begin
    @(negedge clk);
    if (!rstn) e = {1'b1, 1'b0, 1'b0, 8'h00};
    else if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {1'b1, 1'b0, 1'b0, idle_addr};
    act = {uart_tx, busy, done, extout_addr};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("FAIL cycle %0d tx/busy/done/addr: got %b/%b/%b/%02h, expected %b/%b/%b/%02h",
               cyc, act.tx, act.busy, act.done, act.addr, e.tx, e.busy, e.done, e.addr);
    end
    if (rstn && busy && (addr_log.size() == 0 || addr_log[$] !== extout_addr))
      addr_log.push_back(extout_addr);
  end

  // UART receiver: records each start-bit cycle and each decoded byte.
  bit         rx_on = 1'b0;
  int         rx_cnt;
  logic [7:0] rx_sh;
  initial forever begin
    @(negedge clk);
    if (!rstn) rx_on = 1'b0;
    else if (!rx_on) begin
      if (uart_tx === 1'b0) begin rx_on = 1'b1; rx_cnt = 0; start_q.push_back(cyc); end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == 0 && rx_cnt >= CPB && rx_cnt <= 8 * CPB) rx_sh[rx_cnt / CPB - 1] = uart_tx;
      if (rx_cnt == 9 * CPB) begin rx_q.push_back(rx_sh); rx_on = 1'b0; end
    end
  end

  task automatic chk(input string name, input int act_v, input int req_v);
    compared++;
    if (act_v != req_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, req_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_word(input int a);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < NB; j++) w[DATA_W-1-8*j -: 8] = 8'(a * 7 + j * 13 + 1);
    return w;
  endfunction

  task automatic push_frame(input logic [7:0] bt, input logic [7:0] a);
    logic v;
    for (int b = 0; b < 10; b++) begin
      v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bt[b-1];
      repeat (CPB) exp_q.push_back({v, 1'b1, 1'b0, a});
    end
  endtask

  // Whole-dump waveform: per word an idle gap of RD_LAT+1, then NB frames; optional checksum; done.
  task automatic build_expect(input logic [7:0] base, input int n);
    logic [7:0] cs, a, last, bt;
    cs = 8'h00;
    if (n == 0) exp_q.push_back({1'b1, 1'b1, 1'b0, base});
    for (int k = 0; k < n; k++) begin
      a = base + 8'(k);
      repeat (RDL + 1) exp_q.push_back({1'b1, 1'b1, 1'b0, a});
      for (int j = 0; j < NB; j++) begin
        bt = mem[a][DATA_W-1-8*j -: 8];
        cs ^= bt;
        push_frame(bt, a);
      end
    end
    last = (n == 0) ? base : base + 8'(n - 1);
    if (CS && n > 0) push_frame(cs, last);
    exp_q.push_back({1'b1, 1'b0, 1'b1, last});
    idle_addr = last;
  endtask

  task automatic do_start(input logic [7:0] base, input int n, input bit accept);
    if (accept) begin rx_q.delete(); start_q.delete(); addr_log.delete(); end
    @(negedge clk);
    start = 1'b1; base_addr = base; n_words = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin e0 = cyc; build_expect(base, n); end
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; done_at = cyc; end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s: done not seen within %0d cycles", name, max);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = make_word(a);
    mem[8'h10][DATA_W-1 -: 8] = 8'hA5;
    mem[8'h10][7:0] = 8'h3C;
    mem[8'h10][DATA_W-1-8*4 -: 8] = 8'h00;
    for (int j = 0; j < NB; j++) begin
      mem[8'h20][DATA_W-1-8*j -: 8] = 8'h01;
      mem[8'h21][DATA_W-1-8*j -: 8] = 8'(j);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("reset uart_tx", int'(uart_tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset extout_addr", int'(extout_addr), 0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);

    // Single word at 0x10.
    do_start(8'h10, 1, 1'b1);
    wait_done("single done", 3000);
    chk("single byte count", rx_q.size(), NB_EXP);
    chk("single first byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 8'hA5);
    chk("single last data byte", (rx_q.size() > NB - 1) ? int'(rx_q[NB-1]) : -1, 8'h3C);
    chk("single first start bit", (start_q.size() > 0) ? start_q[0] - e0 : -1, 3);
    chk("single done latency", (start_q.size() > 0) ? done_at - start_q[0] : -1, DONE_EXP);

    // Three words wrapping 0xFE -> 0x00, with an ignored start mid-frame.
    do_start(8'hFE, 3, 1'b1);
    repeat (100) @(posedge clk);
    do_start(8'h40, 2, 1'b0);
    wait_done("wrap done", 8000);
    chk("wrap byte count", rx_q.size(), 3 * NB + (CS ? 1 : 0));
    chk("wrap addr count", addr_log.size(), 3);
    chk("wrap addr 0", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 8'hFE);
    chk("wrap addr 1", (addr_log.size() > 1) ? int'(addr_log[1]) : -1, 8'hFF);
    chk("wrap addr 2", (addr_log.size() > 2) ? int'(addr_log[2]) : -1, 8'h00);
    chk("wrap gap 1", (start_q.size() > NB) ? start_q[NB] - start_q[NB-1] - 10 * CPB : -1, 3);
    chk("wrap gap 2", (start_q.size() > 2 * NB) ? start_q[2*NB] - start_q[2*NB-1] - 10 * CPB : -1, 3);

    // Zero length.
    do_start(8'h33, 0, 1'b1);
    wait_done("zero done", 20);
    chk("zero done latency", done_at - e0, 1);
    chk("zero byte count", rx_q.size(), 0);

    // Reset during byte 5's data bits (byte 5 is 0x00, so the line is low).
    do_start(8'h10, 1, 1'b1);
    repeat (175) @(posedge clk);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    idle_addr = 8'h00;
    #1;
    chk("midreset uart_tx", int'(uart_tx), 1);
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset extout_addr", int'(extout_addr), 0);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    do_start(8'h10, 1, 1'b1);
    wait_done("post-reset done", 3000);
    chk("post-reset byte count", rx_q.size(), NB_EXP);
    chk("post-reset first byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 8'hA5);
    chk("post-reset last data byte", (rx_q.size() > NB - 1) ? int'(rx_q[NB-1]) : -1, 8'h3C);

`ifdef PAIRING_UART_TX_CHECKSUM_EN
    do_start(8'h20, 1, 1'b1);
    wait_done("csum ones done", 3000);
    chk("csum of all 0x01", (rx_q.size() > NB) ? int'(rx_q[NB]) : -1, 8'h00);
    do_start(8'h21, 1, 1'b1);
    wait_done("csum ramp done", 3000);
    chk("csum of 0x00..0x25", (rx_q.size() > NB) ? int'(rx_q[NB]) : -1, 8'h01);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
